// File: rtl/rf_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int BUS_MAX   = 256;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Extract field k of width w from a packed bus (zero-extended to BUS_MAX).
    function automatic logic [63:0] rf_field(input logic [BUS_MAX-1:0] bus,
                                             input int unsigned        k,
                                             input int unsigned        w);
        logic [BUS_MAX-1:0] mask;
        mask = (BUS_MAX'(1) << w) - BUS_MAX'(1);
        return 64'((bus >> (k * w)) & mask);
    endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Clear sequencer: sweeps every register to zero after reset or on request,
// one index per cycle, and flags busy for the duration.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                end
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy    = (state_q == RF_CLEAR);
    assign clr_we  = busy;
    assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised integer register file: NRD combinational read ports with
// optional write bypass, hardwired x0, hardware clear sweep and debug port.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int DBG_W  = 16,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                clr_req,
    output logic                busy,
    input  logic [AW-1:0]       dbg_addr,
    output logic [DBG_W-1:0]    dbg_data
);

    logic          clr_we;
    logic [AW-1:0] clr_idx;
    logic          wr_en;

    rf_clear_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // A clear request in the same cycle wins over the write.
    assign wr_en = we && (waddr != '0) && !busy && !clr_req && !rst;

    logic [XLEN-1:0] mem [NREGS];

    // NOTE: the array has no reset branch so it maps onto plain RAM/flops
    // without a reset net; the clear sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_data <= '0;
        end else if (dbg_addr == '0) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= mem[dbg_addr][DBG_W-1:0];
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = AW'(rf_field(BUS_MAX'(raddr), k, AW));

        always_comb begin
            rd = '0;
            if (ra == '0 || busy) begin
                rd = '0;
            end else if (BYPASS != 0 && we && waddr == ra) begin
                rd = wdata;
            end else begin
                rd = mem[ra];
            end
        end

        assign rdata[k*XLEN +: XLEN] = rd;
    end

endmodule
